screen_draw_sequencer: RTL and testbench
========================================

// Module: screen_draw_sequencer
// PURPOSE
//  Sequences all framebuffer writes for the game screens.
//  Accepts one draw command at a time from the game-state controller: clear-screen or sprite-blit.
//  Walks the pixel counters and drives the VGA adapter write port (x, y, colour, plot).
//  Replaces the ad-hoc paint/countUp/controlReset handling in the state FSM; the FSM waits on done.
// PARAMETERS
//  SCREEN_W      160  screen width in pixels
//  SCREEN_H      120  screen height in pixels
//  XW            8    x coordinate width
//  YW            7    y coordinate width
//  SPR_DIM       16   sprite edge length in pixels (square, power of 2)
//  SPR_IDW       4    sprite-id width (up to 16 sprites in ROM)
//  COLW          3    colour width
//  KEY_COLOUR    3'b000  transparent colour (used only with SPRITE_KEY_EN)
// PORTS
//  clk            in   1        system clock
//  reset          in   1        asynchronous, active-high reset
//  cmd_valid      in   1        command present
//  cmd_ready      out  1        sequencer idle, command accepted when valid&ready
//  cmd_op         in   1        0 = clear screen, 1 = sprite blit
//  cmd_x          in   XW       sprite top-left x (ignored for clear)
//  cmd_y          in   YW       sprite top-left y (ignored for clear)
//  cmd_sprite     in   SPR_IDW  sprite id (ignored for clear)
//  cmd_colour     in   COLW     fill colour for clear
//  rom_addr       out  SPR_IDW+2*log2(SPR_DIM)  sprite ROM address {id,row,col}
//  rom_data       in   COLW     sprite ROM pixel, valid 1 cycle after rom_addr
//  vga_x          out  XW       pixel x to adapter
//  vga_y          out  YW       pixel y to adapter
//  vga_colour     out  COLW     pixel colour to adapter
//  vga_plot       out  1        write strobe to adapter
//  busy           out  1        high from acceptance until done
//  done           out  1        1-cycle pulse when command completes
// BEHAVIOUR
//  States: IDLE, CLEAR, BLIT, FLUSH, DONE. cmd_ready = (state==IDLE); no queuing.
//  Reset (async): state IDLE; vga_x/y/colour/plot, rom_addr, busy, done all 0; cmd_ready 1.
//  IDLE: on valid&ready at cycle T latch all cmd fields; op=0 -> CLEAR, op=1 -> BLIT; busy=1 from T+1.
//  CLEAR: raster scan x fastest; plot high T+1..T+W*H, (0,0) first, (W-1,H-1) last, colour=latched.
//   After last pixel -> DONE; done high at T+W*H+1, state IDLE at T+W*H+2.
//  BLIT: col/row counters 0..SPR_DIM-1, col fastest; rom_addr driven T+1..T+SPR_DIM^2.
//   Stage-2 register (1 cycle): vga_x=x0+col, vga_y=y0+row, colour=rom_data, plot at T+2..T+SPR_DIM^2+1.
//   After last address -> FLUSH (1 cycle, emits final pixel) -> DONE; done at T+SPR_DIM^2+2.
//  Clipping: sums computed XW+1 / YW+1 wide; pixel with x>=SCREEN_W or y>=SCREEN_H has plot=0
//   but still consumes its cycle (timing fixed regardless of position). No wrap-around to column 0.
//  vga_plot low in IDLE/DONE; vga_x/y/colour hold last values when plot low.
//  cmd_valid while busy: ignored, cmd_ready=0; requester must hold.
//  Reset mid-command: command abandoned, no done pulse, partial frame left as drawn.
//  done and cmd_ready never both high; new command accepted earliest cycle after done.
// CONFIGURATION
//  SPRITE_KEY_EN defined: in BLIT, pixels with rom_data==KEY_COLOUR have plot=0 (transparent);
//   cycle timing and done timing unchanged. CLEAR unaffected.
//  SPRITE_KEY_EN undefined: every in-bounds sprite pixel plotted, KEY_COLOUR unused.
// TESTING
//  Reset -> all outputs 0, cmd_ready=1; assert reset during CLEAR at pixel 500 -> plot 0 immediately, no done.
//  Clear op, colour 3'b101 -> exactly 19200 plots, coords raster order, done at T+19201, then ready.
//  Blit id 2 at (10,20), ROM = address LSBs -> 256 plots, first (10,20) colour=rom[512], done at T+258.
//  Blit at (150,110) -> only 10x10=100 plots, x<160/y<120, done still at T+258.
//  SPRITE_KEY_EN, sprite with 40 key pixels at (0,0) -> 216 plots; undefined -> 256.
//  cmd_valid held during blit with second op -> ignored until done; accepted cycle after done.

Source files
------------

// File: rtl/screen_draw_sequencer_if.sv
// Draw-command handshake between the game-state controller (master) and the
// screen draw sequencer (slave).
interface screen_draw_sequencer_if #(
  parameter int unsigned XW      = 8,
  parameter int unsigned YW      = 7,
  parameter int unsigned SPR_IDW = 4,
  parameter int unsigned COLW    = 3
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_op;
  logic [XW-1:0]      cmd_x;
  logic [YW-1:0]      cmd_y;
  logic [SPR_IDW-1:0] cmd_sprite;
  logic [COLW-1:0]    cmd_colour;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_sprite, cmd_colour,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_sprite, cmd_colour,
    output cmd_ready
  );
endinterface

// File: rtl/screen_draw_sequencer.sv
// Runs one clear-screen or sprite-blit command at a time onto the VGA adapter write port.
// Optional SPRITE_KEY_EN makes sprite pixels equal to KEY_COLOUR transparent.
module screen_draw_sequencer #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned XW       = 8,
  parameter int unsigned YW       = 7,
  parameter int unsigned SPR_DIM  = 16,
  parameter int unsigned SPR_IDW  = 4,
  parameter int unsigned COLW     = 3
`ifdef SPRITE_KEY_EN
  ,
  parameter logic [COLW-1:0] KEY_COLOUR = '0
`endif
) (
  input  logic                                 clk,
  input  logic                                 reset,
  screen_draw_sequencer_if.slave               cmd,
  output logic [SPR_IDW+2*$clog2(SPR_DIM)-1:0] rom_addr,
  input  logic [COLW-1:0]                      rom_data,
  output logic [XW-1:0]                        vga_x,
  output logic [YW-1:0]                        vga_y,
  output logic [COLW-1:0]                      vga_colour,
  output logic                                 vga_plot,
  output logic                                 busy,
  output logic                                 done
);
  localparam int unsigned LW = $clog2(SPR_DIM);
  localparam int unsigned AW = SPR_IDW + 2 * LW;
  localparam logic [XW:0] XLim  = (XW+1)'(SCREEN_W);
  localparam logic [YW:0] YLim  = (YW+1)'(SCREEN_H);
  localparam logic [XW:0] XLast = (XW+1)'(SCREEN_W - 1);
  localparam logic [YW:0] YLast = (YW+1)'(SCREEN_H - 1);

  typedef enum logic [2:0] {StIdle, StClear, StBlit, StFlush, StDone} state_e;

  state_e          state_q, state_d;
  logic [XW:0]     px_q, px_d;
  logic [YW:0]     py_q, py_d;
  logic            pvalid_q, pvalid_d;
  logic            psrc_q, psrc_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic [XW-1:0]   x0_q, x0_d, hx_q, hx_d;
  logic [YW-1:0]   y0_q, y0_d, hy_q, hy_d;
  logic [COLW-1:0] fill_q, fill_d, hcol_q, hcol_d;

  logic [LW-1:0]   col, row;
  logic            inb, keyok, wr;
  logic [COLW-1:0] pix_col;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      px_q       <= '0;
      py_q       <= '0;
      pvalid_q   <= 1'b0;
      psrc_q     <= 1'b0;
      rom_addr_q <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      fill_q     <= '0;
      hx_q       <= '0;
      hy_q       <= '0;
      hcol_q     <= '0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      pvalid_q   <= pvalid_d;
      psrc_q     <= psrc_d;
      rom_addr_q <= rom_addr_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      fill_q     <= fill_d;
      hx_q       <= hx_d;
      hy_q       <= hy_d;
      hcol_q     <= hcol_d;
    end
  end

  // Output stage: px/py/pvalid hold the pixel presented this cycle; sprite colour arrives from
  // the ROM in the same cycle, so colour and key test are resolved combinationally here.
  always_comb begin
    col = rom_addr_q[LW-1:0];
    row = rom_addr_q[2*LW-1:LW];
    inb = (px_q < XLim) && (py_q < YLim);
`ifdef SPRITE_KEY_EN
    keyok = !psrc_q || (rom_data != KEY_COLOUR);
`else
    keyok = 1'b1;
`endif
    wr      = pvalid_q && inb && keyok;
    pix_col = psrc_q ? rom_data : fill_q;

    vga_plot   = wr;
    vga_x      = wr ? px_q[XW-1:0] : hx_q;
    vga_y      = wr ? py_q[YW-1:0] : hy_q;
    vga_colour = wr ? pix_col : hcol_q;
    rom_addr   = rom_addr_q;
    cmd.cmd_ready = (state_q == StIdle);
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);

    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    pvalid_d   = 1'b0;
    psrc_d     = psrc_q;
    rom_addr_d = rom_addr_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    fill_d     = fill_q;
    hx_d       = wr ? px_q[XW-1:0] : hx_q;
    hy_d       = wr ? py_q[YW-1:0] : hy_q;
    hcol_d     = wr ? pix_col : hcol_q;

    unique case (state_q)
      StIdle: begin
        if (cmd.cmd_valid) begin
          x0_d       = cmd.cmd_x;
          y0_d       = cmd.cmd_y;
          fill_d     = cmd.cmd_colour;
          rom_addr_d = {cmd.cmd_sprite, {(2*LW){1'b0}}};
          if (cmd.cmd_op) begin
            state_d = StBlit;
          end else begin
            state_d  = StClear;
            pvalid_d = 1'b1;
            psrc_d   = 1'b0;
            px_d     = '0;
            py_d     = '0;
          end
        end
      end
      StClear: begin
        if (px_q == XLast && py_q == YLast) begin
          state_d = StDone;
        end else begin
          pvalid_d = 1'b1;
          if (px_q == XLast) begin
            px_d = '0;
            py_d = py_q + 1'b1;
          end else begin
            px_d = px_q + 1'b1;
          end
        end
      end
      StBlit: begin
        // Sums are one bit wider so off-screen pixels clip instead of wrapping.
        pvalid_d = 1'b1;
        psrc_d   = 1'b1;
        px_d     = {1'b0, x0_q} + {{(XW+1-LW){1'b0}}, col};
        py_d     = {1'b0, y0_q} + {{(YW+1-LW){1'b0}}, row};
        if (&rom_addr_q[2*LW-1:0]) state_d = StFlush;
        else                       rom_addr_d = rom_addr_q + 1'b1;
      end
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end
endmodule

// File: tb/tb_screen_draw_sequencer.sv
// Directed self-checking bench for screen_draw_sequencer with a registered sprite ROM model.
module tb_screen_draw_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] rom_addr;
  logic [2:0]  rom_data;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, busy, done;

  screen_draw_sequencer_if #(.XW(8), .YW(7), .SPR_IDW(4), .COLW(3)) cmd ();

  screen_draw_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Sprite 3: first 40 pixels (rows 0-1, row 2 cols 0-7) are colour 0, rest 6.
  // Other sprites: colour = address LSBs.
  function automatic logic [2:0] rom_val(input int unsigned a);
    int unsigned id, r, c;
    id = a / 256;
    r  = (a / 16) % 16;
    c  = a % 16;
    if (id == 3) return (r < 2 || (r == 2 && c < 8)) ? 3'd0 : 3'd6;
    return 3'(a % 8);
  endfunction

  always @(posedge clk) rom_data <= rom_val(32'(rom_addr));

  typedef struct packed {
    int unsigned cyc;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
  } pix_t;

  pix_t        plots[$];
  int unsigned cyc = 0;
  int unsigned done_cnt = 0, both_hi = 0, acc_cnt = 0, acc_cyc = 0;
  int unsigned n_cmp = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vga_plot === 1'b1) plots.push_back('{cyc, vga_x, vga_y, vga_colour});
    if (done === 1'b1) done_cnt++;
    if (done === 1'b1 && cmd.cmd_ready === 1'b1) both_hi++;
    if (cmd.cmd_valid === 1'b1 && cmd.cmd_ready === 1'b1) begin
      acc_cnt++;
      acc_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Presents a command for one cycle; returns the acceptance cycle T, leaves caller in T+1.
  task automatic issue(input logic op, input int unsigned x, input int unsigned y,
                       input int unsigned id, input logic [2:0] colr, input bit hold,
                       output int unsigned t);
    @(posedge clk); #1;
    cmd.cmd_valid  = 1'b1;
    cmd.cmd_op     = op;
    cmd.cmd_x      = 8'(x);
    cmd.cmd_y      = 7'(y);
    cmd.cmd_sprite = 4'(id);
    cmd.cmd_colour = colr;
    t = cyc;
    @(posedge clk); #1;
    if (!hold) cmd.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned limit, output int unsigned dcyc);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < limit);
    chk("done_seen", 32'(done), 32'd1);
    dcyc = cyc;
  endtask

  task automatic run_blit(input string tag, input int unsigned x0, input int unsigned y0,
                          input int unsigned id, input int unsigned exp_cnt);
    int unsigned t, d, idx, bad, ex, ey;
    logic [2:0]  c;
    bit          vis;
    plots.delete();
    issue(1'b1, x0, y0, id, 3'd0, 1'b0, t);
    wait_done(400, d);
    idx = 0;
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      ex  = x0 + k % 16;
      ey  = y0 + k / 16;
      c   = rom_val(id * 256 + k);
      vis = (ex < 160) && (ey < 120);
`ifdef SPRITE_KEY_EN
      vis = vis && (c != 3'd0);
`endif
      if (vis) begin
        if (idx >= plots.size()) bad++;
        else if (plots[idx].cyc != t + 2 + k || plots[idx].x != 8'(ex) ||
                 plots[idx].y != 7'(ey) || plots[idx].c != c) bad++;
        idx++;
      end
    end
    chk({tag, "_count"}, plots.size(), exp_cnt);
    chk({tag, "_order"}, bad, 0);
    chk({tag, "_done_cyc"}, d, t + 258);
  endtask

  initial begin
    int unsigned t, d, bad, dc, a0;
    reset          = 1'b1;
    cmd.cmd_valid  = 1'b0;
    cmd.cmd_op     = 1'b0;
    cmd.cmd_x      = '0;
    cmd.cmd_y      = '0;
    cmd.cmd_sprite = '0;
    cmd.cmd_colour = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_plot", 32'(vga_plot), 0);
    chk("rst_xyc", {vga_x, vga_y, vga_colour}, 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_ready", 32'(cmd.cmd_ready), 1);
    reset = 1'b0;

    // Full clear
    plots.delete();
    issue(1'b0, 0, 0, 0, 3'b101, 1'b0, t);
    repeat (99) @(posedge clk);
    #1;
    chk("clr_busy_ready", {busy, cmd.cmd_ready}, 2'b10);
    wait_done(20000, d);
    bad = 0;
    for (int i = 0; i < plots.size(); i++)
      if (plots[i].cyc != t + 1 + i || plots[i].x != 8'(i % 160) ||
          plots[i].y != 7'(i / 160) || plots[i].c != 3'b101) bad++;
    chk("clr_count", plots.size(), 19200);
    chk("clr_order", bad, 0);
    chk("clr_last_xy", {plots[19199].x, plots[19199].y}, {8'd159, 7'd119});
    chk("clr_done_cyc", d, t + 19201);
    @(negedge clk);
    chk("clr_ready_after", {cmd.cmd_ready, done, vga_plot}, 3'b100);

    // Blits: on-screen, clipped corner, keyed sprite
    run_blit("blit1", 10, 20, 2, 256);
    chk("blit1_first", {plots[0].x, plots[0].y, plots[0].c}, {8'd10, 7'd20, 3'd0});
    chk("blit1_second_c", 32'(plots[1].c), 32'(rom_val(513)));
    run_blit("blit_clip", 150, 110, 2, 100);
`ifdef SPRITE_KEY_EN
    run_blit("blit_key", 0, 0, 3, 216);
`else
    run_blit("blit_key", 0, 0, 3, 256);
`endif

    // Second command held valid while busy
    a0 = acc_cnt;
    issue(1'b1, 10, 20, 2, 3'd0, 1'b1, t);
    cmd.cmd_x = 8'd0;
    cmd.cmd_y = 7'd0;
    wait_done(400, d);
    chk("held_not_taken", acc_cnt - a0, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmd.cmd_valid = 1'b0;
    chk("held_taken", acc_cnt - a0, 2);
    chk("held_acc_cyc", acc_cyc, d + 1);
    wait_done(400, d);

    // Reset in the middle of a clear
    issue(1'b0, 0, 0, 0, 3'b011, 1'b0, t);
    repeat (500) @(posedge clk);
    #1;
    chk("mid_pix500", {vga_plot, vga_x, vga_y}, {1'b1, 8'd20, 7'd3});
    dc = done_cnt;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_plot", 32'(vga_plot), 0);
    chk("mid_rst_state", {busy, cmd.cmd_ready}, 2'b01);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_no_done", done_cnt, dc);
    chk("mid_idle", {busy, vga_plot}, 0);
    chk("done_ready_excl", both_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
